// File: rtl/tqvp_reg_arbiter.sv
// Two-master round-robin arbiter for the TinyQV peripheral register port.
// One transaction at a time, with a read timeout and width-based read-data masking.
module tqvp_reg_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [31:0]       a_wdata,
    input  logic [1:0]        a_write_n,
    input  logic [1:0]        a_read_n,
    output logic              a_ack,
    output logic              a_err,
    output logic [31:0]       a_rdata,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [31:0]       b_wdata,
    input  logic [1:0]        b_write_n,
    input  logic [1:0]        b_read_n,
    output logic              b_ack,
    output logic              b_err,
    output logic [31:0]       b_rdata,
    output logic [ADDR_W-1:0] p_address,
    output logic [31:0]       p_data_in,
    output logic [1:0]        p_data_write_n,
    output logic [1:0]        p_data_read_n,
    input  logic [31:0]       p_data_out,
    input  logic              p_data_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_grantB;
    logic              r_lastGrantB;
    logic              r_err;
    logic [1:0]        r_width;
    logic [7:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_aRdata;
    logic [31:0]       r_bRdata;

    logic              w_aPend;
    logic              w_bPend;
    logic              w_pickB;
    logic [1:0]        w_selWrite_n;
    logic [1:0]        w_selRead_n;
    logic              w_selIsWrite;
    logic [1:0]        w_selWidth;
    logic [31:0]       w_masked;

    assign w_aPend = (a_write_n != 2'b11) || (a_read_n != 2'b11);
    assign w_bPend = (b_write_n != 2'b11) || (b_read_n != 2'b11);

    // Under contention the requester that did not win last time goes first.
    assign w_pickB      = w_bPend && (!w_aPend || !r_lastGrantB);
    assign w_selWrite_n = w_pickB ? b_write_n : a_write_n;
    assign w_selRead_n  = w_pickB ? b_read_n  : a_read_n;
    assign w_selIsWrite = (w_selWrite_n != 2'b11);
    assign w_selWidth   = w_selIsWrite ? w_selWrite_n : w_selRead_n;

    always_comb begin
        w_masked = p_data_out;
        case (r_width)
            2'b00:   w_masked = {24'd0, p_data_out[7:0]};
            2'b01:   w_masked = {16'd0, p_data_out[15:0]};
            default: w_masked = p_data_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grantB     <= 1'b0;
            r_lastGrantB <= 1'b1;
            r_err        <= 1'b0;
            r_width      <= 2'b11;
            r_count      <= 8'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_aRdata     <= 32'd0;
            r_bRdata     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aPend || w_bPend) begin
                        r_grantB <= w_pickB;
                        r_addr   <= w_pickB ? b_address : a_address;
                        r_wdata  <= w_pickB ? b_wdata : a_wdata;
                        r_width  <= w_selWidth;
                        r_err    <= 1'b0;
                        r_count  <= 8'd0;
                        r_state  <= w_selIsWrite ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    r_state <= S_DONE;
                end
                S_READ: begin
                    // Ready wins over an expiring timeout in the same cycle.
                    if (p_data_ready) begin
                        if (r_grantB) r_bRdata <= w_masked;
                        else          r_aRdata <= w_masked;
                        r_state <= S_DONE;
                    end else if ((TIMEOUT != 0) && (r_count == TO_LAST)) begin
                        if (r_grantB) r_bRdata <= 32'd0;
                        else          r_aRdata <= 32'd0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_DONE: begin
                    r_lastGrantB <= r_grantB;
                    r_count      <= 8'd0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_ack          = (r_state == S_DONE) && !r_grantB;
    assign b_ack          = (r_state == S_DONE) &&  r_grantB;
    assign a_err          = a_ack && r_err;
    assign b_err          = b_ack && r_err;
    assign a_rdata        = r_aRdata;
    assign b_rdata        = r_bRdata;
    assign p_address      = r_addr;
    assign p_data_in      = r_wdata;
    assign p_data_write_n = (r_state == S_WRITE) ? r_width : 2'b11;
    assign p_data_read_n  = (r_state == S_READ)  ? r_width : 2'b11;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Directed bench for tqvp_reg_arbiter; cycle 0 is the IDLE cycle in which a request
// is first presented, and outputs are sampled 1 ns after each rising edge.
module tb_tqvp_reg_arbiter;

    logic        clk;
    logic        rst_n;
    logic [5:0]  a_address, b_address;
    logic [31:0] a_wdata, b_wdata;
    logic [1:0]  a_write_n, a_read_n, b_write_n, b_read_n;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [5:0]  p_address;
    logic [31:0] p_data_in;
    logic [1:0]  p_data_write_n, p_data_read_n;
    logic [31:0] p_data_out;
    logic        p_data_ready;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    tqvp_reg_arbiter #(.ADDR_W(6), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_address(a_address), .a_wdata(a_wdata), .a_write_n(a_write_n), .a_read_n(a_read_n),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_address(b_address), .b_wdata(b_wdata), .b_write_n(b_write_n), .b_read_n(b_read_n),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .p_address(p_address), .p_data_in(p_data_in),
        .p_data_write_n(p_data_write_n), .p_data_read_n(p_data_read_n),
        .p_data_out(p_data_out), .p_data_ready(p_data_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic isB, input logic [5:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] wn, input logic [1:0] rn);
        if (isB) begin
            b_address = addr; b_wdata = wdata; b_write_n = wn; b_read_n = rn;
        end else begin
            a_address = addr; a_wdata = wdata; a_write_n = wn; a_read_n = rn;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        p_data_out = 32'd0;
        p_data_ready = 1'b0;
        applyStimulus(1'b0, 6'd0, 32'd0, 2'b11, 2'b11);
        applyStimulus(1'b1, 6'd0, 32'd0, 2'b11, 2'b11);
        nextCycle();
        nextCycle();
        checkOutput("rst_write_n", p_data_write_n, 32'h3);
        checkOutput("rst_read_n",  p_data_read_n,  32'h3);
        checkOutput("rst_addr",    p_address,      32'h0);
        checkOutput("rst_data_in", p_data_in,      32'h0);
        checkOutput("rst_acks",    {a_ack, a_err, b_ack, b_err}, 32'h0);
        checkOutput("rst_a_rdata", a_rdata,        32'h0);
        checkOutput("rst_b_rdata", b_rdata,        32'h0);
        checkOutput("rst_busy",    busy,           32'h0);
        rst_n = 1'b1;
        nextCycle();

        // A word write to 0x05
        applyStimulus(1'b0, 6'h05, 32'hDEADBEEF, 2'b10, 2'b11);
        nextCycle();
        checkOutput("wr_strobe",  p_data_write_n, 32'h2);
        checkOutput("wr_addr",    p_address,      32'h05);
        checkOutput("wr_data",    p_data_in,      32'hDEADBEEF);
        checkOutput("wr_busy",    busy,           32'h1);
        checkOutput("wr_ack_c1",  a_ack,          32'h0);
        nextCycle();
        checkOutput("wr_strobe_c2", p_data_write_n, 32'h3);
        checkOutput("wr_a_ack",   a_ack,          32'h1);
        checkOutput("wr_a_err",   a_err,          32'h0);
        checkOutput("wr_b_ack",   b_ack,          32'h0);
        applyStimulus(1'b0, 6'h05, 32'hDEADBEEF, 2'b11, 2'b11);
        nextCycle();
        checkOutput("wr_ack_c3",  a_ack,          32'h0);
        checkOutput("wr_idle",    busy,           32'h0);

        // B byte read from 0x10, ready arrives in cycle 4
        applyStimulus(1'b1, 6'h10, 32'h0, 2'b11, 2'b00);
        nextCycle();
        checkOutput("rd_strobe",  p_data_read_n,  32'h0);
        checkOutput("rd_addr",    p_address,      32'h10);
        for (int c = 2; c <= 3; c++) begin
            nextCycle();
            checkOutput("rd_wait_ack", b_ack, 32'h0);
        end
        nextCycle();
        p_data_out = 32'h12345678;
        p_data_ready = 1'b1;
        checkOutput("rd_c4_ack",  b_ack,          32'h0);
        nextCycle();
        checkOutput("rd_b_ack",   b_ack,          32'h1);
        checkOutput("rd_b_err",   b_err,          32'h0);
        checkOutput("rd_b_rdata", b_rdata,        32'h00000078);
        checkOutput("rd_a_rdata", a_rdata,        32'h0);
        checkOutput("rd_strobe_done", p_data_read_n, 32'h3);
        p_data_ready = 1'b0;
        applyStimulus(1'b1, 6'h10, 32'h0, 2'b11, 2'b11);
        nextCycle();
        checkOutput("rd_hold_rdata", b_rdata,     32'h00000078);
        checkOutput("rd_ack_gone", b_ack,         32'h0);

        // Contention after B was last served: A first, then B
        applyStimulus(1'b0, 6'h01, 32'h11111111, 2'b10, 2'b11);
        applyStimulus(1'b1, 6'h02, 32'h22222222, 2'b00, 2'b11);
        nextCycle();
        checkOutput("rr1_first_addr", p_address,  32'h01);
        checkOutput("rr1_first_data", p_data_in,  32'h11111111);
        nextCycle();
        checkOutput("rr1_a_ack",  a_ack,          32'h1);
        checkOutput("rr1_b_noack", b_ack,         32'h0);
        applyStimulus(1'b0, 6'h01, 32'h0, 2'b11, 2'b11);
        nextCycle();
        checkOutput("rr1_idle",   busy,           32'h0);
        nextCycle();
        checkOutput("rr1_second_addr", p_address, 32'h02);
        checkOutput("rr1_second_w",    p_data_write_n, 32'h0);
        nextCycle();
        checkOutput("rr1_b_ack",  b_ack,          32'h1);
        checkOutput("rr1_a_noack", a_ack,         32'h0);
        applyStimulus(1'b1, 6'h02, 32'h0, 2'b11, 2'b11);
        nextCycle();

        // Lone A write leaves A as last grant
        applyStimulus(1'b0, 6'h03, 32'h33333333, 2'b10, 2'b11);
        nextCycle();
        nextCycle();
        checkOutput("solo_a_ack", a_ack,          32'h1);
        applyStimulus(1'b0, 6'h03, 32'h0, 2'b11, 2'b11);
        nextCycle();

        // Contention after A was last served: B first
        applyStimulus(1'b0, 6'h04, 32'h44444444, 2'b10, 2'b11);
        applyStimulus(1'b1, 6'h06, 32'h66666666, 2'b01, 2'b11);
        nextCycle();
        checkOutput("rr2_first_addr", p_address,  32'h06);
        checkOutput("rr2_first_w",    p_data_write_n, 32'h1);
        nextCycle();
        checkOutput("rr2_b_ack",  b_ack,          32'h1);
        checkOutput("rr2_a_noack", a_ack,         32'h0);
        applyStimulus(1'b1, 6'h06, 32'h0, 2'b11, 2'b11);
        nextCycle();
        nextCycle();
        checkOutput("rr2_second_addr", p_address, 32'h04);
        nextCycle();
        checkOutput("rr2_a_ack",  a_ack,          32'h1);
        applyStimulus(1'b0, 6'h04, 32'h0, 2'b11, 2'b11);
        nextCycle();

        // A half read with immediate ready: minimum read latency
        p_data_out = 32'hCAFEF00D;
        p_data_ready = 1'b1;
        applyStimulus(1'b0, 6'h08, 32'h0, 2'b11, 2'b01);
        nextCycle();
        checkOutput("hr_strobe",  p_data_read_n,  32'h1);
        nextCycle();
        checkOutput("hr_a_ack",   a_ack,          32'h1);
        checkOutput("hr_a_rdata", a_rdata,        32'h0000F00D);
        p_data_ready = 1'b0;
        applyStimulus(1'b0, 6'h08, 32'h0, 2'b11, 2'b11);
        nextCycle();

        // A half read that times out (TIMEOUT = 4)
        applyStimulus(1'b0, 6'h07, 32'h0, 2'b11, 2'b01);
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            checkOutput("to_wait_ack", a_ack, 32'h0);
            checkOutput("to_wait_strobe", p_data_read_n, 32'h1);
        end
        nextCycle();
        checkOutput("to_a_ack",   a_ack,          32'h1);
        checkOutput("to_a_err",   a_err,          32'h1);
        checkOutput("to_a_rdata", a_rdata,        32'h0);
        applyStimulus(1'b0, 6'h07, 32'h0, 2'b11, 2'b11);
        nextCycle();

        // Next read proceeds normally
        p_data_out = 32'h89ABCDEF;
        p_data_ready = 1'b1;
        applyStimulus(1'b0, 6'h0A, 32'h0, 2'b11, 2'b10);
        nextCycle();
        nextCycle();
        checkOutput("post_to_ack",   a_ack,       32'h1);
        checkOutput("post_to_err",   a_err,       32'h0);
        checkOutput("post_to_rdata", a_rdata,     32'h89ABCDEF);
        p_data_ready = 1'b0;
        applyStimulus(1'b0, 6'h0A, 32'h0, 2'b11, 2'b11);
        nextCycle();

        // Both write and read fields on A: write only
        applyStimulus(1'b0, 6'h09, 32'h55555555, 2'b10, 2'b10);
        nextCycle();
        checkOutput("both_w",     p_data_write_n, 32'h2);
        checkOutput("both_r",     p_data_read_n,  32'h3);
        nextCycle();
        checkOutput("both_ack",   a_ack,          32'h1);
        applyStimulus(1'b0, 6'h09, 32'h0, 2'b11, 2'b11);
        nextCycle();
        nextCycle();
        checkOutput("both_single_ack", a_ack,     32'h0);
        checkOutput("both_idle",  busy,           32'h0);

        // Async reset in the middle of a B read
        applyStimulus(1'b1, 6'h0B, 32'h0, 2'b11, 2'b10);
        nextCycle();
        checkOutput("ar_pre_strobe", p_data_read_n, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_strobe",  p_data_read_n,  32'h3);
        checkOutput("ar_busy",    busy,           32'h0);
        checkOutput("ar_addr",    p_address,      32'h0);
        applyStimulus(1'b1, 6'h0B, 32'h0, 2'b11, 2'b11);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("ar_no_ack",  b_ack,          32'h0);
        checkOutput("ar_b_rdata", b_rdata,        32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
